// File: rtl/uart_rx_apb_fifo.sv
// rtl/uart_rx_apb_fifo.sv - UART receive FIFO exposed over an APB3 slave.
// DATA register pops the head word; STATUS reports level, full and a sticky overrun.
module uart_rx_apb_fifo #(
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 4,
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 16'h2364
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_done_tick,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr,
  output logic              rx_irq
);

  localparam int                PW        = $clog2(DEPTH);
  localparam int                CW        = PW + 1;
  localparam logic [ADDR_W-1:0] STAT_ADDR = BASE_ADDR + ADDR_W'(4);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count, count_nxt;
  logic              overrun, overrun_nxt;
  logic              lat_data, lat_stat, lat_write;
  logic              acc_pop, acc_clr;
  logic              latch_en, go_access, commit;
  logic              full, empty, xfer_err;
  logic              push, pop, clr, ovr_set;
  logic [DATA_W-1:0] status;

  // only the W1C bit of pwdata carries meaning
  logic unused_pwdata;
  assign unused_pwdata = ^{pwdata[DATA_W-1:3], pwdata[1:0]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    latch_en  = 1'b0;
    go_access = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (psel && !penable) begin
          state_nxt = SETUP;
          latch_en  = 1'b1;
        end
      end
      SETUP: begin
        if (!psel) begin
          state_nxt = IDLE;
        end else if (penable) begin
          state_nxt = ACCESS;
          go_access = 1'b1;
        end else begin
          latch_en  = 1'b1;
        end
      end
      ACCESS: begin
        state_nxt = IDLE;
        commit    = psel;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign xfer_err  = !(lat_data || lat_stat) || (lat_data && lat_write) || (lat_data && empty);
  assign pop       = commit && acc_pop;
  assign clr       = commit && acc_clr && pwdata[2];
  // a pop in the same cycle frees the slot, so a full FIFO still accepts the word
  assign push      = rx_done_tick && (!full || pop);
  assign ovr_set   = rx_done_tick && full && !pop;
  assign count_nxt = count + CW'(push) - CW'(pop);
  assign overrun_nxt = ovr_set || (overrun && !clr);

  always_comb begin
    status        = '0;
    status[0]     = !empty;
    status[1]     = full;
    status[2]     = overrun;
    status[15:8]  = 8'(count);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rx_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overrun   <= 1'b0;
      rx_irq    <= 1'b0;
      lat_data  <= 1'b0;
      lat_stat  <= 1'b0;
      lat_write <= 1'b0;
      acc_pop   <= 1'b0;
      acc_clr   <= 1'b0;
      pready    <= 1'b0;
      pslverr   <= 1'b0;
      prdata    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count   <= count_nxt;
      overrun <= overrun_nxt;
      rx_irq  <= (count_nxt != '0) || overrun_nxt;
      if (latch_en) begin
        lat_data  <= (paddr == BASE_ADDR);
        lat_stat  <= (paddr == STAT_ADDR);
        lat_write <= pwrite;
      end
      if (go_access) begin
        pready  <= 1'b1;
        pslverr <= xfer_err;
        if (xfer_err || lat_write) prdata <= '0;
        else if (lat_data)         prdata <= mem[rd_ptr];
        else                       prdata <= status;
        acc_pop <= !xfer_err && lat_data;
        acc_clr <= !xfer_err && lat_stat && lat_write;
      end else begin
        pready  <= 1'b0;
        pslverr <= 1'b0;
        prdata  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_apb_fifo.sv
// tb/tb_uart_rx_apb_fifo.sv - directed and random checks of uart_rx_apb_fifo.
// Expectations come from a queue-based model of the FIFO and register map.
module tb_uart_rx_apb_fifo;

  localparam logic [15:0] BASE = 16'h2364;
  localparam logic [15:0] STAT = 16'h2368;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] rx_data;
  logic        rx_done_tick;
  logic        psel, penable, pwrite;
  logic [15:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready, pslverr, rx_irq;

  uart_rx_apb_fifo dut (
    .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_done_tick(rx_done_tick),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr), .rx_irq(rx_irq)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] q[$];
  logic        ovr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] status_exp();
    return {16'h0, 8'(q.size()), 5'b0, ovr, q.size() == 4, q.size() != 0};
  endfunction

  function automatic logic [31:0] irq_exp();
    return {31'b0, (q.size() != 0) || ovr};
  endfunction

  task automatic push(input logic [31:0] w, input string tag);
    @(negedge clk);
    rx_done_tick = 1'b1;
    rx_data      = w;
    @(negedge clk);
    rx_done_tick = 1'b0;
    if (q.size() < 4) q.push_back(w);
    else              ovr = 1'b1;
    chk({tag, "_irq"}, rx_irq, irq_exp());
  endtask

  task automatic xfer(input logic wr, input logic [15:0] addr, input logic [31:0] wd,
                      input logic tick, input logic [31:0] td, input string tag);
    logic        is_data, is_stat, err, do_pop, do_clr, set;
    logic [31:0] exp_rd;
    is_data = (addr == BASE);
    is_stat = (addr == STAT);
    err     = !(is_data || is_stat) || (is_data && wr) || (is_data && q.size() == 0);
    exp_rd  = 32'h0;
    if (!err && is_data)       exp_rd = q[0];
    else if (!err && !wr)      exp_rd = status_exp();
    do_pop  = !err && is_data;
    do_clr  = !err && is_stat && wr && wd[2];
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
    @(negedge clk);
    penable = 1'b1;
    chk({tag, "_wait"}, pready, 0);
    @(negedge clk);
    chk({tag, "_ready"}, pready, 1);
    chk({tag, "_prdata"}, prdata, exp_rd);
    chk({tag, "_pslverr"}, pslverr, err);
    rx_done_tick = tick;
    rx_data      = td;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; rx_done_tick = 1'b0;
    set = tick && q.size() == 4 && !do_pop;
    if (do_pop) void'(q.pop_front());
    if (tick && q.size() < 4) q.push_back(td);
    ovr = set ? 1'b1 : (do_clr ? 1'b0 : ovr);
    chk({tag, "_idle_ready"}, pready, 0);
    chk({tag, "_idle_prdata"}, prdata, 0);
    chk({tag, "_irq"}, rx_irq, irq_exp());
  endtask

  initial begin
    logic [31:0] w;
    int          r;
    reset_n = 1'b0; rx_done_tick = 1'b0; rx_data = '0;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    ovr = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_pready", pready, 0);
    chk("rst_prdata", prdata, 0);
    chk("rst_pslverr", pslverr, 0);
    chk("rst_irq", rx_irq, 0);
    reset_n = 1'b1;
    xfer(0, STAT, 0, 0, 0, "rst_status");

    push(32'hA5A5_0001, "t1_push");
    xfer(0, BASE, 0, 0, 0, "t1_read");
    xfer(0, STAT, 0, 0, 0, "t1_status");

    for (int i = 1; i <= 5; i++) push(32'h1000_0000 + i, "t2_push");
    xfer(0, STAT, 0, 0, 0, "t2_status");
    for (int i = 0; i < 4; i++) xfer(0, BASE, 0, 0, 0, "t2_read");
    xfer(1, STAT, 32'h4, 0, 0, "t2_clear");

    for (int i = 0; i < 4; i++) push($urandom, "t3_push");
    xfer(0, BASE, 0, 1, 32'hC0DE_0003, "t3_read_push");
    xfer(0, STAT, 0, 0, 0, "t3_status");
    for (int i = 0; i < 4; i++) xfer(0, BASE, 0, 0, 0, "t3_drain");

    xfer(0, BASE, 0, 0, 0, "t4_empty_read");
    push(32'h4444_0004, "t4_push");
    xfer(1, BASE, 32'hFFFF_FFFF, 0, 0, "t4_write_data");
    xfer(0, BASE + 16'd8, 0, 0, 0, "t4_bad_addr");
    xfer(0, STAT, 0, 0, 0, "t4_status");
    xfer(0, BASE, 0, 0, 0, "t4_read");

    for (int i = 0; i < 5; i++) push($urandom, "t5_push");
    for (int i = 0; i < 4; i++) xfer(0, BASE, 0, 0, 0, "t5_drain");
    xfer(1, STAT, 32'h4, 0, 0, "t5_clear");
    for (int i = 0; i < 5; i++) push($urandom, "t5b_push");
    xfer(1, STAT, 32'h4, 1, 32'hDEAD_0005, "t5_clear_vs_set");
    xfer(0, STAT, 0, 0, 0, "t5_status");
    for (int i = 0; i < 4; i++) xfer(0, BASE, 0, 0, 0, "t5b_drain");
    xfer(1, STAT, 32'h4, 0, 0, "t5b_clear");

    push(32'h6666_0001, "t6_push");
    push(32'h6666_0002, "t6_push");
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = BASE;
    @(negedge clk);
    psel = 1'b0;
    @(negedge clk);
    chk("t6_abort_ready", pready, 0);
    xfer(0, STAT, 0, 0, 0, "t6_after_abort");

    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 16'h0000;
    @(negedge clk);
    paddr = BASE;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    chk("t6_resetup_ready", pready, 1);
    chk("t6_resetup_err", pslverr, 0);
    chk("t6_resetup_data", prdata, q[0]);
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
    void'(q.pop_front());
    xfer(0, STAT, 0, 0, 0, "t6_after_resetup");

    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = BASE;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    chk("t6_mid_ready", pready, 1);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_ready", pready, 0);
    chk("t6_rst_prdata", prdata, 0);
    chk("t6_rst_irq", rx_irq, 0);
    q.delete();
    ovr = 1'b0;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; reset_n = 1'b1;
    xfer(0, STAT, 0, 0, 0, "t6_after_rst");

    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 6);
      w = $urandom;
      case (r)
        0, 1: push(w, "rnd_push");
        2:    xfer(0, BASE, 0, $urandom_range(0, 2) == 0, w, "rnd_read");
        3:    xfer(0, STAT, 0, $urandom_range(0, 2) == 0, w, "rnd_status");
        4:    xfer(1, STAT, $urandom, $urandom_range(0, 2) == 0, w, "rnd_w1c");
        5:    xfer(1'($urandom), 16'($urandom), $urandom, 0, w, "rnd_addr");
        default: xfer(1, BASE, $urandom, 0, w, "rnd_wdata");
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
